// File: rtl/bsg_chip_link_concentrator.sv
// bsg_chip_link_concentrator
//
// N-to-1 wormhole concentrator for ready-and NoC links. Each input link feeds
// a small FIFO. An arbiter in IDLE picks one non-empty FIFO, either round-robin
// or fixed-priority as selected by rr_en_i. It then holds that grant in SEND
// until the whole packet (header + L body flits) has left, so packets from
// different sources never interleave.
//
// Ports:
//   clk_i        core clock
//   reset_n_i    asynchronous active-low reset
//   data_i       num_in_p input flits, channel k at [k*flit_width_p +: flit_width_p]
//   v_i          per-channel valid
//   ready_and_o  per-channel ready (FIFO not full, low during reset)
//   data_o       concentrated flit (head of the granted FIFO)
//   v_o          output valid (SEND and granted FIFO non-empty)
//   ready_and_i  downstream ready
//   rr_en_i      1: round-robin, 0: fixed priority (lowest index); sampled in IDLE
//   grant_id_o   channel currently granted; holds its last value in IDLE
//   busy_o       high while in SEND
module bsg_chip_link_concentrator #(
    parameter int unsigned num_in_p     = 4,
    parameter int unsigned flit_width_p = 64,
    parameter int unsigned len_offset_p = 8,
    parameter int unsigned len_width_p  = 4,
    parameter int unsigned fifo_els_p   = 2
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [num_in_p*flit_width_p-1:0]   data_i,
    input  logic [num_in_p-1:0]                v_i,
    output logic [num_in_p-1:0]                ready_and_o,
    output logic [flit_width_p-1:0]            data_o,
    output logic                               v_o,
    input  logic                               ready_and_i,
    input  logic                               rr_en_i,
    output logic [$clog2(num_in_p)-1:0]        grant_id_o,
    output logic                               busy_o
);

    localparam int unsigned GW = $clog2(num_in_p);
    localparam int unsigned PW = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int unsigned CW = $clog2(fifo_els_p + 1);

    localparam logic [CW-1:0] FullCnt   = CW'(fifo_els_p);
    localparam logic [PW-1:0] LastPtr   = PW'(fifo_els_p - 1);
    localparam logic [GW-1:0] LastGrant = GW'(num_in_p - 1);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    // ------------------------------------------------------------------
    // Per-channel FIFOs
    // ------------------------------------------------------------------
    logic [flit_width_p-1:0] r_mem  [num_in_p][fifo_els_p];
    logic [PW-1:0]           r_wptr [num_in_p];
    logic [PW-1:0]           r_rptr [num_in_p];
    logic [CW-1:0]           r_fill [num_in_p];
    logic [num_in_p-1:0]     r_full;

    logic [CW-1:0]           w_fill_nxt [num_in_p];
    logic [flit_width_p-1:0] w_head     [num_in_p];
    logic [num_in_p-1:0]     w_head_v;
    logic [num_in_p-1:0]     w_enq;
    logic [num_in_p-1:0]     w_deq;

    // FSM state
    state_e                  r_state;
    logic [GW-1:0]           r_grant;
    logic [GW-1:0]           r_ptr;
    logic [len_width_p-1:0]  r_cnt;
    logic                    r_busy;

    logic                    w_xfer;
    logic                    w_found;
    logic [GW-1:0]           w_win;
    logic [GW-1:0]           w_idx;
    logic [len_width_p-1:0]  w_win_len;

    // Ready comes from the registered full flag, so a full FIFO refuses input
    // even in a cycle where it dequeues. Forced low while reset is asserted.
    assign ready_and_o = ~r_full & {num_in_p{reset_n_i}};
    assign w_enq       = v_i & ready_and_o;

    assign w_xfer = (r_state == StSend) && w_head_v[r_grant] && ready_and_i;

    always_comb begin
        for (int unsigned k = 0; k < num_in_p; k++) begin
            w_head_v[k] = (r_fill[k] != '0);
            w_head[k]   = r_mem[k][r_rptr[k]];
            w_deq[k]    = w_xfer && (r_grant == GW'(k));
            w_fill_nxt[k] = r_fill[k];
            unique case ({w_enq[k], w_deq[k]})
                2'b10:   w_fill_nxt[k] = r_fill[k] + CW'(1);
                2'b01:   w_fill_nxt[k] = r_fill[k] - CW'(1);
                default: w_fill_nxt[k] = r_fill[k];
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by r_fill.
    always_ff @(posedge clk_i) begin
        for (int unsigned k = 0; k < num_in_p; k++) begin
            if (w_enq[k]) begin
                r_mem[k][r_wptr[k]] <= data_i[k*flit_width_p +: flit_width_p];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned k = 0; k < num_in_p; k++) begin
                r_wptr[k] <= '0;
                r_rptr[k] <= '0;
                r_fill[k] <= '0;
            end
            r_full <= '0;
        end else begin
            for (int unsigned k = 0; k < num_in_p; k++) begin
                if (w_enq[k]) begin
                    r_wptr[k] <= (r_wptr[k] == LastPtr) ? '0 : r_wptr[k] + PW'(1);
                end
                if (w_deq[k]) begin
                    r_rptr[k] <= (r_rptr[k] == LastPtr) ? '0 : r_rptr[k] + PW'(1);
                end
                r_fill[k] <= w_fill_nxt[k];
                r_full[k] <= (w_fill_nxt[k] == FullCnt);
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbitration (only consumed in IDLE)
    // ------------------------------------------------------------------
    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= num_in_p) begin
            s = s - num_in_p;
        end
        return s[GW-1:0];
    endfunction

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned i = 0; i < num_in_p; i++) begin
            w_idx = rr_en_i ? rr_idx(r_ptr, i) : GW'(i);
            if (!w_found && w_head_v[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // FIFO heads seen in IDLE are always headers: a grant drains a whole packet.
    assign w_win_len = w_head[w_win][len_offset_p +: len_width_p];

    // ------------------------------------------------------------------
    // Packet FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= StIdle;
            r_grant <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_grant <= w_win;
                        r_cnt   <= w_win_len;
                        r_state <= StSend;
                        r_busy  <= 1'b1;
                    end
                end
                StSend: begin
                    // A source stall simply leaves w_xfer low; the grant is kept.
                    if (w_xfer) begin
                        if (r_cnt == '0) begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                            r_ptr   <= (r_grant == LastGrant) ? '0 : r_grant + GW'(1);
                        end else begin
                            r_cnt <= r_cnt - len_width_p'(1);
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign v_o        = (r_state == StSend) && w_head_v[r_grant];
    assign data_o     = w_head[r_grant];
    assign grant_id_o = r_grant;
    assign busy_o     = r_busy;

endmodule

// File: tb/tb_bsg_chip_link_concentrator.sv
// Testbench for bsg_chip_link_concentrator: per-channel source queues drive the
// inputs, and expected output flits (with their expected channel) are queued in
// output order and compared whenever the DUT transfers a flit.
module tb_bsg_chip_link_concentrator;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int GW = 2;

    logic              clk;
    logic              reset_n_i;
    logic [N*W-1:0]    data_i;
    logic [N-1:0]      v_i;
    logic [N-1:0]      ready_and_o;
    logic [W-1:0]      data_o;
    logic              v_o;
    logic              ready_and_i;
    logic              rr_en_i;
    logic [GW-1:0]     grant_id_o;
    logic              busy_o;

    bsg_chip_link_concentrator #(
        .num_in_p     (N),
        .flit_width_p (W),
        .len_offset_p (8),
        .len_width_p  (4),
        .fifo_els_p   (2)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n_i),
        .data_i      (data_i),
        .v_i         (v_i),
        .ready_and_o (ready_and_o),
        .data_o      (data_o),
        .v_o         (v_o),
        .ready_and_i (ready_and_i),
        .rr_en_i     (rr_en_i),
        .grant_id_o  (grant_id_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        int          ch;
    } exp_t;

    exp_t        exp_q [$];
    logic [63:0] src_q [N][$];
    int          xfer_tick [$];
    int          n_total, n_bad, cyc, n_xfer;
    logic        prev_stall;
    logic [63:0] prev_data;
    logic        rdy_next, rr_next;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Flit i of packet (ch, seq); body flits carry len=F so a mis-framed body
    // taken as a header would be visible.
    function automatic logic [63:0] fl(input int ch, input int seq, input int len, input int i);
        logic [3:0] lf;
        lf = (i == 0) ? 4'(len) : 4'hF;
        return {4'(ch), 36'(seq), 8'(i), 4'h0, lf, 8'h5A};
    endfunction

    task automatic src_pkt(input int ch, input int seq, input int len, input int from, input int to);
        for (int i = from; i <= to; i++) src_q[ch].push_back(fl(ch, seq, len, i));
    endtask

    task automatic exp_pkt(input int ch, input int seq, input int len, input int upto);
        exp_t e;
        for (int i = 0; i <= upto; i++) begin
            e.d  = fl(ch, seq, len, i);
            e.ch = ch;
            exp_q.push_back(e);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (prev_stall) begin
            check("hold_v", 64'(v_o), 64'd1);
            check("hold_data", data_o, prev_data);
        end
        if (v_o && ready_and_i) begin
            if (exp_q.size() == 0) begin
                check("extra_flit", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("data", data_o, e.d);
                check("grant", 64'(grant_id_o), 64'(e.ch));
            end
            n_xfer++;
            xfer_tick.push_back(cyc);
        end
        prev_stall = v_o && !ready_and_i;
        prev_data  = data_o;
    endtask

    // One cycle: retire accepted source flits at the edge, drive the next
    // inputs 1 ns later, observe outputs on the falling edge.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            if (v_i[k] && ready_and_o[k]) void'(src_q[k].pop_front());
        end
        #1;
        for (int k = 0; k < N; k++) begin
            v_i[k]             = (src_q[k].size() > 0);
            data_i[k*W +: W]   = (src_q[k].size() > 0) ? src_q[k][0] : '0;
        end
        ready_and_i = rdy_next;
        rr_en_i     = rr_next;
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    task automatic clear_all();
        for (int k = 0; k < N; k++) src_q[k].delete();
        exp_q.delete();
        xfer_tick.delete();
        v_i        = '0;
        data_i     = '0;
        prev_stall = 1'b0;
        n_xfer     = 0;
    endtask

    task automatic apply_reset();
        reset_n_i = 1'b0;
        clear_all();
        rdy_next    = 1'b1;
        rr_next     = 1'b1;
        ready_and_i = 1'b1;
        rr_en_i     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n_i = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_xfer(input string tag, input int cnt, input int budget);
        int n;
        n = 0;
        while (n_xfer < cnt && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(n_xfer), 64'(cnt));
    endtask

    initial begin
        n_total = 0; n_bad = 0; cyc = 0;
        reset_n_i = 1'b1;
        clear_all();
        ready_and_i = 1'b1; rr_en_i = 1'b1; rdy_next = 1'b1; rr_next = 1'b1;

        // Reset values while reset is held, then ready rises on release.
        #2 reset_n_i = 1'b0;
        #1;
        check("rst_ready", 64'(ready_and_o), 64'd0);
        check("rst_v", 64'(v_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_grant", 64'(grant_id_o), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n_i = 1'b1;
        #1;
        check("rel_ready", 64'(ready_and_o), 64'hF);

        // Single channel, L=3
        apply_reset();
        src_pkt(0, 1, 3, 0, 3);
        exp_pkt(0, 1, 3, 3);
        tick(); check("t1_v_drive", 64'(v_o), 64'd0);
        tick(); check("t1_v_arb", 64'(v_o), 64'd0);
        tick(); check("t1_v_rise", 64'(v_o), 64'd1);
        check("t1_busy", 64'(busy_o), 64'd1);
        repeat (3) begin
            tick(); check("t1_v_cont", 64'(v_o), 64'd1);
        end
        tick();
        check("t1_busy_fall", 64'(busy_o), 64'd0);
        check("t1_grant", 64'(grant_id_o), 64'd0);
        check("t1_count", 64'(n_xfer), 64'd4);
        check("t1_left", 64'(exp_q.size()), 64'd0);

        // Round-robin with single-flit packets on all channels
        apply_reset();
        for (int s = 0; s < 3; s++) begin
            for (int ch = 0; ch < N; ch++) begin
                src_pkt(ch, 10 + s, 0, 0, 0);
                exp_pkt(ch, 10 + s, 0, 0);
            end
        end
        drain("t2_drain", 80);
        check("t2_count", 64'(n_xfer), 64'd12);
        for (int i = 1; i < xfer_tick.size(); i++) begin
            check("t2_rr_gap", 64'(xfer_tick[i] - xfer_tick[i-1]), 64'd2);
        end

        // Fixed priority: move the RR pointer to 2 first, so only fixed priority picks 1 over 3
        apply_reset();
        src_pkt(1, 20, 0, 0, 0);
        exp_pkt(1, 20, 0, 0);
        drain("t3_pre", 20);
        rr_next = 1'b0;
        src_pkt(1, 21, 2, 0, 2);
        src_pkt(3, 22, 2, 0, 2);
        exp_pkt(1, 21, 2, 2);
        exp_pkt(3, 22, 2, 2);
        repeat (3) tick();
        check("t3_grant1", 64'(grant_id_o), 64'd1);
        rr_next = 1'b1;
        tick();
        rr_next = 1'b0;
        drain("t3_drain", 40);

        // Stall mid-packet on channel 2 with channel 0 pending
        apply_reset();
        src_pkt(2, 30, 2, 0, 0);
        exp_pkt(2, 30, 2, 2);
        exp_pkt(0, 31, 1, 1);
        repeat (3) tick();
        check("t4_grant", 64'(grant_id_o), 64'd2);
        check("t4_busy", 64'(busy_o), 64'd1);
        src_pkt(0, 31, 1, 0, 1);
        repeat (5) begin
            tick();
            check("t4_gap_v", 64'(v_o), 64'd0);
            check("t4_gap_grant", 64'(grant_id_o), 64'd2);
        end
        src_pkt(2, 30, 2, 1, 2);
        drain("t4_drain", 40);

        // Backpressure 1,0,0,1 during an L=3 packet
        apply_reset();
        src_pkt(0, 40, 3, 0, 3);
        exp_pkt(0, 40, 3, 3);
        wait_xfer("t5_first", 1, 10);
        rdy_next = 1'b0;
        tick();
        tick();
        check("t5_full_ready", 64'(ready_and_o[0]), 64'd0);
        check("t5_stall_v", 64'(v_o), 64'd1);
        rdy_next = 1'b1;
        drain("t5_drain", 20);

        // Reset after the 2nd flit of an L=3 packet
        apply_reset();
        src_pkt(2, 50, 3, 0, 3);
        exp_pkt(2, 50, 3, 1);
        wait_xfer("t6_two", 2, 12);
        @(posedge clk);
        #2 reset_n_i = 1'b0;
        #1;
        check("t6_v_async", 64'(v_o), 64'd0);
        check("t6_busy", 64'(busy_o), 64'd0);
        check("t6_grant", 64'(grant_id_o), 64'd0);
        check("t6_ready", 64'(ready_and_o), 64'd0);
        clear_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n_i = 1'b1;
        tick();
        check("t6_ready_rel", 64'(ready_and_o), 64'hF);
        check("t6_idle", 64'(busy_o), 64'd0);
        repeat (3) begin
            tick();
            check("t6_no_stale", 64'(v_o), 64'd0);
        end
        src_pkt(1, 51, 0, 0, 0);
        exp_pkt(1, 51, 0, 0);
        drain("t6_drain", 20);
        check("t6_count", 64'(n_xfer), 64'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
